// File: rtl/g2b_pkg.sv
// Shared types and defaults for the bit-serial Gray-to-binary decoder.
package g2b_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int G2B_WIDTH_DEF = 4;

endpackage

// File: rtl/gray_to_binary_seq_if.sv
// Handshake bundle for gray_to_binary_seq: Gray word in, binary word out, status.
interface gray_to_binary_seq_if
    import g2b_pkg::*;
#(
    parameter int WIDTH = G2B_WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bin_out;
    logic             busy;
    logic             step_err;

    modport master (
        output in_valid, gray_in, out_ready,
        input  in_ready, out_valid, bin_out, busy, step_err
    );

    modport slave (
        input  in_valid, gray_in, out_ready,
        output in_ready, out_valid, bin_out, busy, step_err
    );
endinterface

// File: rtl/gray_step_check.sv
// Flags accepted Gray words that differ from the previous accepted word in other
// than exactly one bit. The first word after reset is never flagged.
module gray_step_check #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [WIDTH-1:0] gray_in,
    output logic             step_err
);

    logic [WIDTH-1:0] prev_gray_r;
    logic             first_r;
    logic             step_err_r;
    logic             bad_step_s;

    // True when exactly one bit of d is set (popcount == 1).
    function automatic logic one_bit_set(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] dm1;
        dm1 = d - {{(WIDTH-1){1'b0}}, 1'b1};
        return (d != {WIDTH{1'b0}}) && ((d & dm1) == {WIDTH{1'b0}});
    endfunction

    // Violation on this accept, before prev/first are updated.
    always_comb begin
        bad_step_s = 1'b0;
        if (accept && !first_r) begin
            bad_step_s = !one_bit_set(prev_gray_r ^ gray_in);
        end else begin
            bad_step_s = 1'b0;
        end
    end

    // History register, first-word flag and the one-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_gray_r <= {WIDTH{1'b0}};
            first_r     <= 1'b1;
            step_err_r  <= 1'b0;
        end else begin
            step_err_r <= bad_step_s;
            if (accept) begin
                prev_gray_r <= gray_in;
                first_r     <= 1'b0;
            end else begin
                prev_gray_r <= prev_gray_r;
                first_r     <= first_r;
            end
        end
    end

    assign step_err = step_err_r;

endmodule

// File: rtl/gray_to_binary_seq.sv
// Bit-serial Gray-to-binary decoder, MSB first, one bit per clock, valid/ready on both sides.
// Optional build macro STEP_CHECK_EN adds the Gray single-step checker on step_err.
module gray_to_binary_seq
    import g2b_pkg::*;
#(
    parameter int WIDTH = G2B_WIDTH_DEF
) (
    input logic                  clk,
    input logic                  rst,
    gray_to_binary_seq_if.slave  bus
);

    localparam int               IDX_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] g_reg_r;
    logic [WIDTH-1:0] b_reg_r;
    logic [WIDTH-1:0] b_next_s;
    logic [WIDTH-1:0] bin_out_r;
    logic [IDX_W-1:0] idx_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             accept_s;
    logic             release_s;
    logic             last_s;
    logic             upper_s;

    assign accept_s  = (state_r == IDLE) && bus.in_valid;
    assign release_s = (state_r == DONE) && bus.out_ready;
    assign last_s    = (state_r == CONV) && (idx_r == {IDX_W{1'b0}});

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = CONV;
                else          state_s = IDLE;
            end
            CONV: begin
                if (last_s) state_s = DONE;
                else        state_s = CONV;
            end
            DONE: begin
                if (release_s) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Resolve bit idx: MSB copies Gray, lower bits XOR with the already-resolved bit above.
    always_comb begin
        upper_s  = 1'b0;
        b_next_s = b_reg_r;
        if (idx_r == IDX_MAX) begin
            upper_s = 1'b0;
        end else begin
            upper_s = b_reg_r[idx_r + IDX_W'(1)];
        end
        b_next_s[idx_r] = upper_s ^ g_reg_r[idx_r];
    end

    // Datapath: capture, shift-resolve, and the registered output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_reg_r     <= {WIDTH{1'b0}};
            b_reg_r     <= {WIDTH{1'b0}};
            idx_r       <= IDX_MAX;
            bin_out_r   <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (accept_s) begin
            g_reg_r <= bus.gray_in;
            b_reg_r <= {WIDTH{1'b0}};
            idx_r   <= IDX_MAX;
            busy_r  <= 1'b1;
        end else if (state_r == CONV) begin
            b_reg_r <= b_next_s;
            if (last_s) begin
                bin_out_r   <= b_next_s;
                out_valid_r <= 1'b1;
            end else begin
                idx_r <= idx_r - IDX_W'(1);
            end
        end else if (release_s) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.bin_out   = bin_out_r;
    assign bus.busy      = busy_r;

`ifdef STEP_CHECK_EN
    gray_step_check #(
        .WIDTH (WIDTH)
    ) u_step_check (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept_s),
        .gray_in  (bus.gray_in),
        .step_err (bus.step_err)
    );
`else
    assign bus.step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_binary_seq.sv
// Directed bench for gray_to_binary_seq at WIDTH=4.
module tb_gray_to_binary_seq;

`ifdef STEP_CHECK_EN
    localparam logic STEP_EN = 1'b1;
`else
    localparam logic STEP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [3:0] exp_tab [16];

    gray_to_binary_seq_if #(.WIDTH(4)) bus ();

    gray_to_binary_seq #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer with out_ready high; checks decode and the step_err pulse.
    task automatic xfer(input string tag, input logic [3:0] g, input logic [3:0] b, input logic err);
        bus.gray_in  = g;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_step_err"}, bus.step_err, err);
        tick();
        chk({tag, "_step_err_end"}, bus.step_err, 1'b0);
        tick(); tick(); tick();
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_bin"}, bus.bin_out, b);
        tick();
    endtask

    initial begin
        exp_tab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                    4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.gray_in   = 4'd0;
        bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        tick(); tick();
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_bin_out", bus.bin_out, 4'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_step_err", bus.step_err, 1'b0);
        rst = 1'b0;
        tick();

        // 1: single word, exact latency
        bus.gray_in   = 4'b1000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("t1_busy", bus.busy, 1'b1);
        chk("t1_in_ready", bus.in_ready, 1'b0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t1_early_valid", bus.out_valid, 1'b0);
        end
        tick();
        chk("t1_valid", bus.out_valid, 1'b1);
        chk("t1_bin", bus.bin_out, 4'd15);
        tick();
        chk("t1_release", bus.out_valid, 1'b0);
        chk("t1_idle_busy", bus.busy, 1'b0);
        chk("t1_idle_ready", bus.in_ready, 1'b1);

        // 2: exhaustive, back-to-back; gray_in scrambled during CONV
        bus.in_valid = 1'b1;
        for (int g = 0; g < 16; g++) begin
            bus.gray_in = 4'(g);
            tick();
            chk("t2_in_ready_conv", bus.in_ready, 1'b0);
            bus.gray_in = ~4'(g);
            tick(); tick(); tick(); tick();
            chk("t2_valid", bus.out_valid, 1'b1);
            chk("t2_bin", bus.bin_out, exp_tab[g]);
            chk("t2_in_ready_done", bus.in_ready, 1'b0);
            tick();
            chk("t2_release", bus.out_valid, 1'b0);
        end
        bus.in_valid = 1'b0;

        // 3: backpressure holds result; new input ignored
        bus.gray_in   = 4'b0110;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.gray_in = 4'b1111;
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", bus.out_valid, 1'b1);
            chk("t3_hold_bin", bus.bin_out, 4'd4);
            chk("t3_hold_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("t3_release", bus.out_valid, 1'b0);
        chk("t3_bin_kept", bus.bin_out, 4'd4);

        // 4: async reset mid-CONV
        bus.gray_in  = 4'b1010;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("t4_out_valid", bus.out_valid, 1'b0);
        chk("t4_busy", bus.busy, 1'b0);
        chk("t4_bin", bus.bin_out, 4'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t4_in_ready", bus.in_ready, 1'b1);
        chk("t4_no_valid", bus.out_valid, 1'b0);

        // 5/6: step checker sequence (expectations follow the build)
        xfer("t5_w0", 4'b0010, 4'd3, 1'b0);
        xfer("t5_w1", 4'b0111, 4'd5, STEP_EN);
        xfer("t5_w2", 4'b0101, 4'd6, 1'b0);
        xfer("t5_w3", 4'b0101, 4'd6, STEP_EN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
